// File: rtl/secuenciador_notas.sv
// Melody sequencer: walks the note ROM address, holds each note for a fixed time,
// inserts a silence between notes and turns the ROM half-period into a square wave.
module secuenciador_notas #(
  parameter int NUM_NOTAS       = 25,
  parameter int CICLOS_NOTA     = 3000000,
  parameter int CICLOS_SILENCIO = 600000,
  parameter int ANCHO_DUR       = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iniciar,
  input  logic        detener,
  input  logic        repetir,
  input  logic [15:0] frecuencia_de_nota,
  output logic [4:0]  direccion_nota,
  output logic        audio,
  output logic        reproduciendo,
  output logic        fin
);

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SONANDO  = 2'd1,
    SILENCIO = 2'd2
  } estado_t;

  localparam logic [4:0]           ULTIMA_NOTA  = 5'(NUM_NOTAS - 1);
  localparam logic [ANCHO_DUR-1:0] FIN_NOTA     = ANCHO_DUR'(CICLOS_NOTA - 1);
  localparam logic [ANCHO_DUR-1:0] FIN_SILENCIO = ANCHO_DUR'(CICLOS_SILENCIO - 1);

  estado_t              estado_q, estado_d;
  logic [ANCHO_DUR-1:0] dur_q, dur_d;
  logic [15:0]          tono_q, tono_d;
  logic [4:0]           dir_q, dir_d;
  logic                 audio_q, audio_d;
  logic                 repro_q, repro_d;
  logic                 fin_q, fin_d;

  always_comb begin
    estado_d = estado_q;
    dur_d    = dur_q;
    tono_d   = tono_q;
    dir_d    = dir_q;
    audio_d  = audio_q;
    repro_d  = repro_q;
    fin_d    = 1'b0;

    if (detener) begin
      // Stop wins over start and over a note ending in the same cycle.
      estado_d = REPOSO;
      dur_d    = '0;
      tono_d   = '0;
      dir_d    = '0;
      audio_d  = 1'b0;
      repro_d  = 1'b0;
    end else begin
      unique case (estado_q)
        REPOSO: begin
          dur_d   = '0;
          tono_d  = '0;
          dir_d   = '0;
          audio_d = 1'b0;
          repro_d = 1'b0;
          if (iniciar) begin
            estado_d = SONANDO;
            repro_d  = 1'b1;
          end
        end

        SONANDO: begin
          // The >= compare keeps the divider sane if the period shrinks mid-note.
          if (frecuencia_de_nota == 16'd0) begin
            tono_d  = '0;
            audio_d = 1'b0;
          end else if (tono_q >= frecuencia_de_nota - 16'd1) begin
            tono_d  = '0;
            audio_d = ~audio_q;
          end else begin
            tono_d = tono_q + 16'd1;
          end

          if (dur_q == FIN_NOTA) begin
            dur_d   = '0;
            tono_d  = '0;
            audio_d = 1'b0;
            if (dir_q < ULTIMA_NOTA) begin
              estado_d = SILENCIO;
              dir_d    = dir_q + 5'd1;
            end else if (repetir) begin
              estado_d = SILENCIO;
              dir_d    = '0;
            end else begin
              estado_d = REPOSO;
              dir_d    = '0;
              repro_d  = 1'b0;
              fin_d    = 1'b1;
            end
          end else begin
            dur_d = dur_q + ANCHO_DUR'(1);
          end
        end

        SILENCIO: begin
          audio_d = 1'b0;
          tono_d  = '0;
          if (dur_q == FIN_SILENCIO) begin
            dur_d    = '0;
            estado_d = SONANDO;
          end else begin
            dur_d = dur_q + ANCHO_DUR'(1);
          end
        end

        default: begin
          estado_d = REPOSO;
          dur_d    = '0;
          tono_d   = '0;
          dir_d    = '0;
          audio_d  = 1'b0;
          repro_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      dur_q    <= '0;
      tono_q   <= '0;
      dir_q    <= '0;
      audio_q  <= 1'b0;
      repro_q  <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      dur_q    <= dur_d;
      tono_q   <= tono_d;
      dir_q    <= dir_d;
      audio_q  <= audio_d;
      repro_q  <= repro_d;
      fin_q    <= fin_d;
    end
  end

  assign direccion_nota = dir_q;
  assign audio          = audio_q;
  assign reproduciendo  = repro_q;
  assign fin            = fin_q;

endmodule

// File: tb/tb_secuenciador_notas.sv
// Bench for secuenciador_notas: a timeline reference model predicts every cycle's
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_secuenciador_notas;

  localparam int NUM  = 3;
  localparam int CN   = 20;
  localparam int CS   = 4;
  localparam int SLOT = CN + CS;
  localparam int CICLO_COMPLETO = NUM * SLOT;
  localparam int ULTIMO_CICLO   = (NUM - 1) * SLOT + CN - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iniciar, detener, repetir;
  logic [15:0] frecuencia_de_nota;
  logic [4:0]  direccion_nota;
  logic        audio, reproduciendo, fin;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Model state: running flag and elapsed cycles since the first note cycle.
  bit         m_run;
  int         m_t;
  logic       m_fin, m_audio, m_repro;
  logic [4:0] m_dir;

  always #5 clk = ~clk;

  secuenciador_notas #(
    .NUM_NOTAS(NUM), .CICLOS_NOTA(CN), .CICLOS_SILENCIO(CS), .ANCHO_DUR(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .detener(detener),
    .repetir(repetir), .frecuencia_de_nota(frecuencia_de_nota),
    .direccion_nota(direccion_nota), .audio(audio),
    .reproduciendo(reproduciendo), .fin(fin)
  );

  function automatic int rom(input int a);
    case (a)
      0: return 3;
      1: return 0;
      2: return 2;
      default: return 0;
    endcase
  endfunction

  always_comb frecuencia_de_nota = 16'(rom(int'(direccion_nota)));

  function automatic void model_outputs();
    int pos, nota, off, f;
    if (!m_run) begin
      m_dir = 5'd0; m_audio = 1'b0; m_repro = 1'b0;
    end else begin
      pos  = m_t % CICLO_COMPLETO;
      nota = pos / SLOT;
      off  = pos % SLOT;
      m_repro = 1'b1;
      if (off < CN) begin
        m_dir   = 5'(nota);
        f       = rom(nota);
        m_audio = (f == 0) ? 1'b0 : 1'(((off / f) % 2));
      end else begin
        m_dir   = (nota == NUM - 1) ? 5'd0 : 5'(nota + 1);
        m_audio = 1'b0;
      end
    end
  endfunction

  function automatic void model_edge(input logic ini, input logic det, input logic rep);
    m_fin = 1'b0;
    if (!rst_n || det) m_run = 1'b0;
    else if (!m_run) begin
      if (ini) begin m_run = 1'b1; m_t = 0; end
    end else if ((m_t % CICLO_COMPLETO) == ULTIMO_CICLO && !rep) begin
      m_run = 1'b0;
      m_fin = 1'b1;
    end else m_t++;
    model_outputs();
  endfunction

  task automatic step(input logic ini, input logic det, input logic rep);
    @(negedge clk); #1;
    iniciar = ini; detener = det; repetir = rep;
    model_edge(ini, det, rep);
    exp_q.push_back({m_repro, m_fin, m_dir, m_audio});
  endtask

  task automatic idle(input int n, input logic rep);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rep);
  endtask

  task automatic check_now(input string name, input logic [7:0] req);
    checks++;
    if ({reproduciendo, fin, direccion_nota, audio} !== req) begin
      errors++;
      $display("FAIL %s: got repro/fin/dir/audio=%b/%b/%0d/%b required %b/%b/%0d/%b",
               name, reproduciendo, fin, direccion_nota, audio,
               req[7], req[6], req[5:1], req[0]);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_now("cycle", e);
    end
  end

  initial begin
    logic rep_lvl;
    bit   found;
    rst_n = 1'b0; iniciar = 1'b0; detener = 1'b0; repetir = 1'b0;
    m_run = 1'b0; m_t = 0; m_fin = 1'b0;
    model_outputs();
    #3 check_now("reset_state", 8'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    idle(3, 1'b0);

    // Single pass without repeat, then idle past the fin pulse.
    step(1'b1, 1'b0, 1'b0);
    idle(75, 1'b0);

    // Looping pass, stopped after it wraps to note 0.
    step(1'b1, 1'b0, 1'b1);
    idle(100, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    idle(3, 1'b0);

    // Stop together with start at cycle 10 of note 1.
    step(1'b1, 1'b0, 1'b0);
    idle(SLOT + 9, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(5, 1'b0);

    // Start re-pulsed mid-note 0 is ignored.
    step(1'b1, 1'b0, 1'b0);
    idle(8, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(30, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Asynchronous reset while note 2 is high.
    step(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (m_audio && m_dir == 5'd2) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL reset_wait: got no high audio in note 2 required one within 200 cycles");
    end else begin
      @(posedge clk); #2;
      check_now("before_reset", exp_q.pop_front());
      rst_n = 1'b0;
      m_run = 1'b0; m_fin = 1'b0;
      model_outputs();
      #1 check_now("async_reset", 8'd0);
      idle(3, 1'b0);
      rst_n = 1'b1;
      idle(10, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      idle(30, 1'b0);
    end

    // Randomized control traffic.
    rep_lvl = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) rep_lvl = ~rep_lvl;
      step(1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 149) == 0), rep_lvl);
    end

    @(negedge clk); @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
